// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_responder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam logic        CMD_READ          = 1'b0;
   localparam logic        CMD_WRITE         = 1'b1;
   localparam logic [15:0] DEFAULT_HALT_ADDR = 16'hFFFE;

endpackage

// File: rtl/dmem_bank_ram.sv
// Two 8-bit byte lanes sharing one word index; per-lane write enable, registered read.
module dmem_bank_ram #(
   parameter int ADDR_BITS = 16
) (
   input  logic                 clk,
   input  logic [ADDR_BITS-2:0] addr_i,
   input  logic                 we_hi_i,
   input  logic                 we_lo_i,
   input  logic [7:0]           wdat_hi_i,
   input  logic [7:0]           wdat_lo_i,
   output logic [7:0]           rdat_hi_o,
   output logic [7:0]           rdat_lo_o
);
   localparam int DEPTH = 1 << (ADDR_BITS - 1);

   logic [7:0] mem_hi_q [DEPTH];
   logic [7:0] mem_lo_q [DEPTH];
   logic [7:0] rdat_hi_q, rdat_lo_q;

   always_ff @(posedge clk) begin
      if (we_hi_i) mem_hi_q[addr_i] <= wdat_hi_i;
      if (we_lo_i) mem_lo_q[addr_i] <= wdat_lo_i;
      rdat_hi_q <= mem_hi_q[addr_i];
      rdat_lo_q <= mem_lo_q[addr_i];
   end

   assign rdat_hi_o = rdat_hi_q;
   assign rdat_lo_o = rdat_lo_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, done WAIT_STATES+2 cycles after acceptance
// with a single-cycle rdy strobe; requests presented while busy wait until IDLE.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int          ADDR_BITS   = 16,
   parameter int          WAIT_STATES = 0,
   parameter logic [15:0] HALT_ADDR   = DEFAULT_HALT_ADDR
) (
   input  logic        clk,
   input  logic        a_rst,
   input  logic        d_mem_assert,
   input  logic        d_mem_cmd,
   input  logic        d_mem_be0,
   input  logic        d_mem_be1,
   input  logic [15:0] d_mem_addr,
   input  logic [15:0] d_mem_data_out,
   output logic [15:0] d_mem_data_in,
   output logic        d_mem_rdy,
   output logic        halt
);
   localparam int IDX_BITS = ADDR_BITS - 1;

   state_e               state_q, state_d;
   logic [3:0]           cnt_q;
   logic                 cmd_q, be0_q, be1_q;
   logic [ADDR_BITS-1:0] addr_q;
   logic [15:0]          wdat_q, rdat_q;
   logic                 rdy_q, halt_q;

   logic                 accept, access, is_word, is_halt_addr;
   logic                 we_hi, we_lo;
   logic [IDX_BITS-1:0]  ram_idx;
   logic [7:0]           wdat_hi, rd_hi, rd_lo;
   logic [15:0]          rd_word;

   always_ff @(posedge clk) begin
      if (!a_rst) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (d_mem_assert) state_d = BUSY;
         BUSY:    if (cnt_q == 4'd0) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The RAM is read at the accepting edge from the live address, so its output is
   // valid for the whole BUSY phase; a reset landing in BUSY suppresses the write.
   always_comb begin
      accept       = (state_q == IDLE) && d_mem_assert;
      access       = (state_q == BUSY) && (cnt_q == 4'd0);
      is_word      = be0_q && be1_q;
      ram_idx      = (state_q == IDLE) ? d_mem_addr[ADDR_BITS-1:1] : addr_q[ADDR_BITS-1:1];
      we_hi        = access && a_rst && (cmd_q == CMD_WRITE) && (is_word || !addr_q[0]);
      we_lo        = access && a_rst && (cmd_q == CMD_WRITE) && (is_word || addr_q[0]);
      wdat_hi      = is_word ? wdat_q[15:8] : wdat_q[7:0];
      rd_word      = is_word ? {rd_hi, rd_lo} : {8'h00, (addr_q[0] ? rd_lo : rd_hi)};
      is_halt_addr = (addr_q[ADDR_BITS-1:1] == HALT_ADDR[ADDR_BITS-1:1]);
   end

   always_ff @(posedge clk) begin
      if (!a_rst) begin
         cnt_q  <= 4'd0;
         cmd_q  <= CMD_READ;
         be0_q  <= 1'b0;
         be1_q  <= 1'b0;
         addr_q <= '0;
         wdat_q <= 16'h0000;
         rdat_q <= 16'h0000;
         rdy_q  <= 1'b0;
         halt_q <= 1'b0;
      end else begin
         rdy_q <= access;
         if (accept) begin
            cnt_q  <= 4'(WAIT_STATES);
            cmd_q  <= d_mem_cmd;
            be0_q  <= d_mem_be0;
            be1_q  <= d_mem_be1;
            addr_q <= d_mem_addr[ADDR_BITS-1:0];
            wdat_q <= d_mem_data_out;
         end else if ((state_q == BUSY) && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
         end
         if (access && (cmd_q == CMD_READ)) rdat_q <= rd_word;
         if (access && (cmd_q == CMD_WRITE) && is_halt_addr) halt_q <= 1'b1;
      end
   end

   dmem_bank_ram #(
      .ADDR_BITS (ADDR_BITS)
   ) u_ram (
      .clk       (clk),
      .addr_i    (ram_idx),
      .we_hi_i   (we_hi),
      .we_lo_i   (we_lo),
      .wdat_hi_i (wdat_hi),
      .wdat_lo_i (wdat_q[7:0]),
      .rdat_hi_o (rd_hi),
      .rdat_lo_o (rd_lo)
   );

   assign d_mem_data_in = rdat_q;
   assign d_mem_rdy     = rdy_q;
   assign halt          = halt_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: unit 0 has WAIT_STATES=0, unit 1 has WAIT_STATES=3; a byte-array
// model predicts each response, a negedge monitor pops and compares on every rdy strobe.
module tb_dmem_responder;
   import dmem_responder_pkg::*;

   typedef struct {
      logic [15:0] dat;
      logic        hlt;
      int          acc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]       rst_n, asrt, cmd, be0, be1, rdy, halt;
   logic [1:0][15:0] addr, wdat, rdat;

   dmem_responder #(.ADDR_BITS(16), .WAIT_STATES(0), .HALT_ADDR(16'hFFFE)) dut0 (
      .clk(clk), .a_rst(rst_n[0]), .d_mem_assert(asrt[0]), .d_mem_cmd(cmd[0]),
      .d_mem_be0(be0[0]), .d_mem_be1(be1[0]), .d_mem_addr(addr[0]),
      .d_mem_data_out(wdat[0]), .d_mem_data_in(rdat[0]), .d_mem_rdy(rdy[0]), .halt(halt[0]));

   dmem_responder #(.ADDR_BITS(16), .WAIT_STATES(3), .HALT_ADDR(16'hFFFE)) dut3 (
      .clk(clk), .a_rst(rst_n[1]), .d_mem_assert(asrt[1]), .d_mem_cmd(cmd[1]),
      .d_mem_be0(be0[1]), .d_mem_be1(be1[1]), .d_mem_addr(addr[1]),
      .d_mem_data_out(wdat[1]), .d_mem_data_in(rdat[1]), .d_mem_rdy(rdy[1]), .halt(halt[1]));

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   exp_t             sb0[$];
   exp_t             sb1[$];
   logic [7:0]       mem_m [0:1][0:65535];
   logic [1:0]       hlt_m;
   logic [1:0][15:0] last_m;
   bit   [1:0]       in_resp;
   logic [1:0]       rdy_prev = 2'b00;

   function automatic int ws_of(input int u);
      return (u == 0) ? 0 : 3;
   endfunction

   task automatic finish_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   endtask

   task automatic check_val(input int u, input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s unit%0d cycle %0d: got %0h expected %0h", nm, u, cyc, act, exp);
      end
   endtask

   task automatic mon_resp(input int u);
      exp_t e;
      bit   have;
      have = 1'b0;
      if (u == 0 && sb0.size() > 0) begin e = sb0.pop_front(); have = 1'b1; end
      if (u == 1 && sb1.size() > 0) begin e = sb1.pop_front(); have = 1'b1; end
      if (!have) begin
         checks++;
         errors++;
         $display("FAIL spurious_rdy unit%0d cycle %0d: got rdy 1 expected 0", u, cyc);
      end else begin
         check_val(u, "rd_data", 32'(rdat[u]), 32'(e.dat));
         check_val(u, "latency", cyc + 1 - e.acc, ws_of(u) + 2);
         check_val(u, "halt", 32'(halt[u]), 32'(e.hlt));
         check_val(u, "rdy_pulse", 32'(rdy_prev[u]), 0);
      end
   endtask

   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (rdy[u] === 1'b1) mon_resp(u);
      end
      rdy_prev = rdy;
   end

   // Memory viewed as a flat byte array; even byte is the high half of a word.
   task automatic model_apply(input int u, input logic c, input logic b0, input logic b1,
                              input logic [15:0] a, input logic [15:0] d);
      logic [15:0] ea, oa;
      ea = a & 16'hFFFE;
      oa = a | 16'h0001;
      if (c == CMD_WRITE) begin
         if (b0 && b1) begin
            mem_m[u][ea] = d[15:8];
            mem_m[u][oa] = d[7:0];
         end else begin
            mem_m[u][a] = d[7:0];
         end
         if (oa == 16'hFFFF) hlt_m[u] = 1'b1;
      end else begin
         if (b0 && b1) last_m[u] = {mem_m[u][ea], mem_m[u][oa]};
         else          last_m[u] = {8'h00, mem_m[u][a]};
      end
   endtask

   // Presents a request at the current negedge and returns at the negedge showing rdy.
   task automatic txn(input int u, input logic c, input logic b0, input logic b1,
                      input logic [15:0] a, input logic [15:0] d);
      exp_t e;
      int   n;
      int   edges;
      edges = in_resp[u] ? 2 : 1;
      e.acc = cyc + edges;
      in_resp[u] = 1'b0;
      model_apply(u, c, b0, b1, a, d);
      e.dat = last_m[u];
      e.hlt = hlt_m[u];
      if (u == 0) sb0.push_back(e); else sb1.push_back(e);
      asrt[u] = 1'b1; cmd[u] = c; be0[u] = b0; be1[u] = b1; addr[u] = a; wdat[u] = d;
      repeat (edges) @(posedge clk);
      @(negedge clk);
      // Core keeps asserting while busy, with a different request on the bus.
      cmd[u]  = 1'($urandom_range(0, 1));
      be0[u]  = 1'($urandom_range(0, 1));
      be1[u]  = 1'($urandom_range(0, 1));
      addr[u] = 16'($urandom);
      wdat[u] = 16'($urandom);
      n = 0;
      while (rdy[u] !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (rdy[u] !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL rdy_timeout unit%0d cycle %0d: got no rdy expected rdy within 40 cycles", u, cyc);
         finish_run();
      end
      asrt[u] = 1'b0;
      in_resp[u] = 1'b1;
   endtask

   task automatic idle(input int u, input int n);
      if (n > 0) begin
         repeat (n) @(negedge clk);
         in_resp[u] = 1'b0;
      end
   endtask

   task automatic do_reset(input int u);
      rst_n[u] = 1'b0;
      asrt[u]  = 1'b0;
      @(negedge clk);
      check_val(u, "rst_rdy", 32'(rdy[u]), 0);
      check_val(u, "rst_data", 32'(rdat[u]), 0);
      check_val(u, "rst_halt", 32'(halt[u]), 0);
      rst_n[u]   = 1'b1;
      hlt_m[u]   = 1'b0;
      last_m[u]  = 16'h0000;
      in_resp[u] = 1'b0;
   endtask

   function automatic logic [15:0] rnd_addr();
      logic [7:0] hi;
      hi = 8'h01;
      case ($urandom_range(0, 3))
         0: hi = 8'hB0;
         1: hi = 8'h12;
         2: hi = 8'hC0;
         default: hi = 8'h01;
      endcase
      return {hi, 4'h0, 4'($urandom_range(0, 15))};
   endfunction

   task automatic rnd_txn(input int u);
      logic [1:0] be;
      be = 2'($urandom_range(0, 3));
      idle(u, $urandom_range(0, 2));
      txn(u, 1'($urandom_range(0, 1)), be[1], be[0], rnd_addr(), 16'($urandom));
   endtask

   initial begin
      #200000;
      checks++;
      errors++;
      $display("FAIL watchdog cycle %0d: got no end expected completion", cyc);
      finish_run();
   end

   initial begin
      rst_n = 2'b00; asrt = 2'b00; cmd = 2'b00; be0 = 2'b00; be1 = 2'b00;
      addr = '0; wdat = '0; hlt_m = 2'b00; last_m = '0; in_resp = 2'b00;
      for (int i = 0; i < 32768; i++) begin
         dut0.u_ram.mem_hi_q[i] = 8'(i >> 7);
         dut0.u_ram.mem_lo_q[i] = 8'(i >> 7);
         dut3.u_ram.mem_hi_q[i] = 8'(i >> 7);
         dut3.u_ram.mem_lo_q[i] = 8'(i >> 7);
      end
      for (int a = 0; a < 65536; a++) begin
         mem_m[0][a] = 8'(a >> 8);
         mem_m[1][a] = 8'(a >> 8);
      end
      @(negedge clk);
      do_reset(1);
      do_reset(0);

      // Directed word/byte sequence; first request lands in the cycle after reset release.
      txn(0, CMD_READ,  1'b1, 1'b1, 16'hC012, 16'h0000);
      txn(0, CMD_WRITE, 1'b1, 1'b1, 16'hB001, 16'hA55A);
      txn(0, CMD_READ,  1'b1, 1'b1, 16'hB000, 16'h0000);
      txn(0, CMD_READ,  1'b1, 1'b0, 16'hB001, 16'h0000);
      txn(0, CMD_WRITE, 1'b0, 1'b1, 16'hB000, 16'h0077);
      txn(0, CMD_READ,  1'b1, 1'b1, 16'hB000, 16'h0000);
      txn(0, CMD_READ,  1'b0, 1'b1, 16'hB000, 16'h0000);

      for (int k = 0; k < 150; k++) rnd_txn(0);

      // Reset during BUSY of a word write abandons it.
      idle(0, 1);
      asrt[0] = 1'b1; cmd[0] = CMD_WRITE; be0[0] = 1'b1; be1[0] = 1'b1;
      addr[0] = 16'h0100; wdat[0] = 16'h1234;
      @(negedge clk);
      do_reset(0);
      idle(0, 2);
      txn(0, CMD_READ, 1'b1, 1'b1, 16'h0100, 16'h0000);

      // Halt is sticky across reads and cleared only by reset.
      txn(0, CMD_WRITE, 1'b0, 1'b0, 16'hFFFF, 16'($urandom));
      txn(0, CMD_READ,  1'b1, 1'b1, 16'hB000, 16'h0000);
      rnd_txn(0);
      do_reset(0);

      for (int k = 0; k < 30; k++) rnd_txn(1);
      txn(1, CMD_WRITE, 1'b1, 1'b1, 16'hFFFE, 16'hBEEF);
      txn(1, CMD_READ,  1'b0, 1'b1, 16'hFFFF, 16'h0000);

      repeat (6) @(negedge clk);
      check_val(0, "sb_drained", sb0.size(), 0);
      check_val(1, "sb_drained", sb1.size(), 0);
      finish_run();
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter ADDR_BITS, default 16: byte-address bits decoded; upper address bits ignored, so accesses wrap modulo 2^ADDR_BITS.
REQ-002 Parameter WAIT_STATES, default 0: extra cycles inserted before completion; legal range 0..15.
REQ-003 Parameter HALT_ADDR, default 16'hFFFE: write address that sets halt.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 a_rst  input  1  reset, synchronous, active-low.
REQ-006 d_mem_assert  input  1  request valid; held by the core until d_mem_rdy.
REQ-007 d_mem_cmd  input  1  1 = write, 0 = read.
REQ-008 d_mem_be0  input  1  byte enable, high byte lane [15:8].
REQ-009 d_mem_be1  input  1  byte enable, low byte lane [7:0].
REQ-010 d_mem_addr  input  16  byte address.
REQ-011 d_mem_data_out  input  16  write data from the core.
REQ-012 d_mem_data_in  output  16  read data to the core, registered.
REQ-013 d_mem_rdy  output  1  completion strobe, one cycle wide, registered.
REQ-014 halt  output  1  sticky flag: a write to HALT_ADDR has completed.

Function
REQ-015 FSM states: IDLE, BUSY, RESP.
- IDLE: d_mem_assert=1 captures cmd, be0, be1, addr and data_out. Next state is BUSY with wait counter = WAIT_STATES.
REQ-016 BUSY: decrement the counter each cycle; when counter==0 perform the access and go to RESP.
REQ-017 RESP: d_mem_rdy=1 for exactly this cycle; next state is IDLE unconditionally.
REQ-018 Latency: rdy is asserted WAIT_STATES+2 cycles after the accepting edge. Peak throughput is one transaction per WAIT_STATES+3 cycles.
REQ-019 Word access (be0&be1):
- addr[0] is ignored.
- Write stores data_out[15:8] at the even byte and data_out[7:0] at the odd byte.
- Read returns {even byte, odd byte}.
REQ-020 Byte access (any other be combination):
- Write stores data_out[7:0] at addr, into the even/high lane when addr[0]=0 and the odd/low lane when addr[0]=1.
- Read returns {8'h00, byte at addr}.
REQ-021 Writes update the array only in the BUSY->RESP transition cycle.
- d_mem_data_in is unchanged on writes.
- d_mem_data_in holds its last read value outside RESP.
REQ-022 Request inputs are ignored in BUSY and RESP; captured values are used for the whole transaction.
REQ-023 halt sets at the completing edge of any write whose captured addr[ADDR_BITS-1:1] equals HALT_ADDR[ADDR_BITS-1:1], word or byte; halt clears only on reset.
REQ-024 Read of a location never written returns array initial content, which is undefined for synthesis (the bench preloads it).

Reset
REQ-025 a_rst=0 at a rising edge forces state IDLE, counter 0, d_mem_rdy 0, d_mem_data_in 16'h0000 and halt 0.
REQ-026 Reset in BUSY abandons the transaction: no array write, no rdy.
REQ-027 Array contents are not affected by reset.
REQ-028 d_mem_assert sampled in the first cycle after reset release is accepted normally.

Structure
REQ-029 Shared package holds:
- FSM state enum (IDLE/BUSY/RESP).
- CMD_READ/CMD_WRITE constants.
- Default HALT_ADDR.
REQ-030 One sub-module, dmem_bank_ram: two 8-bit byte lanes of 2^(ADDR_BITS-1) entries each, with per-lane write enable and a synchronous read port; the FSM and lane steering stay in dmem_responder.

Verification
REQ-031 WAIT_STATES=0, byte array preloaded with addr[15:8]: word read at 16'hC012 -> rdy on cycle 2 after acceptance, data_in=16'hC0C0.
REQ-032 Word write 16'hA55A to 16'hB001, then word read at 16'hB000 -> 16'hA55A; byte read at 16'hB001 -> 16'h005A.
REQ-033 Byte write 16'h0077 to 16'hB000, then word read 16'hB000 -> 16'h775A; byte read 16'hB000 -> 16'h0077.
REQ-034 WAIT_STATES=3: any read -> rdy exactly 5 cycles after acceptance, single-cycle pulse; a new request presented during BUSY is not accepted until IDLE.
REQ-035 Reset asserted in the BUSY cycle of a word write 16'h1234 to 16'h0100 -> no rdy, and a subsequent read of 16'h0100 returns the preload 16'h0101.
REQ-036 Byte write to 16'hFFFF -> halt=1 after the completing edge and stays 1 through later reads; a reset pulse -> halt=0.
